// File: rtl/path_replayer.sv
// path_replayer
//   Drains the maze solver's 2-bit direction stack into a local buffer.
//   The stack pops the most recent move first. The block then replays the
//   moves in forward order (start cell to goal) on a valid/ready stream.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high; forces IDLE and zeroes outputs
//   i_start        one-cycle request, honoured in IDLE only
//   i_stack_dir    stack data (popped value, visible the cycle after o_stack_pop)
//   i_stack_empty  stack holds no entries (post-pop count, one cycle after pop)
//   o_stack_pop    one-cycle pop pulse to the stack
//   o_out_dir      replayed direction (0 whenever o_out_valid=0)
//   o_out_valid    o_out_dir carries a move
//   i_out_ready    downstream accepts o_out_dir this cycle
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse when the replay has finished
//   o_path_len     number of moves captured, held until the next accepted start
//   o_overflow     sticky: drain stopped at DEPTH while the stack was non-empty
//   o_state        current FSM state, for observation
//
// Output handshake: a move transfers on every rising edge where
// o_out_valid && i_out_ready. While o_out_valid is high and i_out_ready is low,
// o_out_dir and o_out_valid hold. o_out_valid only falls after a transfer.
// Back-to-back transfers run at one move per cycle.
module path_replayer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  parameter int CW    = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_stack_dir,
  input  logic             i_stack_empty,
  output logic             o_stack_pop,
  output logic [WIDTH-1:0] o_out_dir,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [CW-1:0]    o_path_len,
  output logic             o_overflow,
  output logic [2:0]       o_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_POP     = 3'd2,
    S_CAPTURE = 3'd3,
    S_PLAY    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CW-1:0]    r_wr_cnt;
  logic [CW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_path_len;
  logic             r_overflow;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_dir;
  logic [WIDTH-1:0] r_buf [DEPTH];

  logic [CW-1:0]    w_cnt_inc;
  logic [AW-1:0]    w_rd_dec;
  logic             w_clear;
  logic             w_capture;
  logic             w_cap_full;
  logic             w_play_enter;
  logic             w_load_first;
  logic             w_xfer;
  logic             w_xfer_last;

  assign w_cnt_inc = r_wr_cnt + CW'(1);
  assign w_rd_dec  = r_rd_ptr[AW-1:0] - AW'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state control strobes
  always_comb begin
    w_state_nxt  = r_state;
    o_stack_pop  = 1'b0;
    o_done       = 1'b0;
    w_clear      = 1'b0;
    w_capture    = 1'b0;
    w_cap_full   = 1'b0;
    w_play_enter = 1'b0;
    w_load_first = 1'b0;
    w_xfer       = 1'b0;
    w_xfer_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clear     = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_nxt = i_stack_empty ? S_FINISH : S_POP;
      end
      S_POP: begin
        o_stack_pop = 1'b1;
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture = 1'b1;
        // An empty stack wins over the depth limit, so a stack holding
        // exactly DEPTH entries does not flag overflow.
        if (i_stack_empty) begin
          w_play_enter = 1'b1;
          w_state_nxt  = S_PLAY;
        end else if (w_cnt_inc == CW'(DEPTH)) begin
          w_cap_full   = 1'b1;
          w_play_enter = 1'b1;
          w_state_nxt  = S_PLAY;
        end else begin
          w_state_nxt = S_POP;
        end
      end
      S_PLAY: begin
        // Within PLAY, o_out_valid is low only in the first cycle. Use that
        // cycle to load the first move.
        if (!r_out_valid) begin
          w_load_first = 1'b1;
        end else if (i_out_ready) begin
          w_xfer = 1'b1;
          if (r_rd_ptr == '0) begin
            w_xfer_last = 1'b1;
            w_state_nxt = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counters, status and registered output stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_cnt    <= '0;
      r_rd_ptr    <= '0;
      r_path_len  <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_dir   <= '0;
    end else begin
      if (w_clear) begin
        r_wr_cnt   <= '0;
        r_path_len <= '0;
        r_overflow <= 1'b0;
      end
      if (w_capture) begin
        r_wr_cnt <= w_cnt_inc;
      end
      if (w_cap_full) begin
        r_overflow <= 1'b1;
      end
      if (w_play_enter) begin
        // The write count includes the entry captured on this edge. The
        // newest slot, the first step from the start cell, is replayed first.
        r_path_len <= w_cnt_inc;
        r_rd_ptr   <= r_wr_cnt;
      end
      if (w_load_first) begin
        r_out_valid <= 1'b1;
        r_out_dir   <= r_buf[r_rd_ptr[AW-1:0]];
      end
      if (w_xfer) begin
        if (w_xfer_last) begin
          r_out_valid <= 1'b0;
          r_out_dir   <= '0;
        end else begin
          r_rd_ptr  <= r_rd_ptr - CW'(1);
          r_out_dir <= r_buf[w_rd_dec];
        end
      end
    end
  end

  // Path buffer, deliberately without reset
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf[r_wr_cnt[AW-1:0]] <= i_stack_dir;
    end
  end

  assign o_out_dir   = r_out_dir;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_path_len  = r_path_len;
  assign o_overflow  = r_overflow;
  assign o_state     = r_state;

endmodule

// File: tb/tb_path_replayer.sv
// tb_path_replayer
//   Bench for path_replayer. A behavioural stack model feeds the DUT.
//   A scoreboard queue holds the moves expected on the output stream.
//   A negedge monitor compares every transfer and records pop, transfer
//   and done cycles. Directed scenarios then check counts, latencies and
//   status.
module tb_path_replayer;
  localparam int WIDTH = 2;
  localparam int DEPTH = 256;
  localparam int CW    = 9;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic             start     = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] stack_dir = '0;
  logic             stack_empty;
  logic             stack_pop;
  logic [WIDTH-1:0] out_dir;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [CW-1:0]    path_len;
  logic             overflow;
  logic [2:0]       state;

  path_replayer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start),
    .i_stack_dir  (stack_dir),
    .i_stack_empty(stack_empty),
    .o_stack_pop  (stack_pop),
    .o_out_dir    (out_dir),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_path_len   (path_len),
    .o_overflow   (overflow),
    .o_state      (state)
  );

  // Stack model: a popped value appears on stack_dir, and the count drops,
  // from the cycle after the pulse.
  logic             push_en   = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic [WIDTH-1:0] stk[$];
  int               stk_cnt = 0;
  assign stack_empty = (stk_cnt == 0);

  always @(posedge clk) begin
    if (push_en) begin
      stk.push_back(push_data);
      stk_cnt <= stk_cnt + 1;
    end else if (stack_pop && stk.size() > 0) begin
      stack_dir <= stk.pop_back();
      stk_cnt   <= stk_cnt - 1;
    end
  end

  // Scoreboard state
  logic [WIDTH-1:0] exp_q[$];
  int pop_cyc_q[$];
  int hs_cyc_q[$];
  int done_cyc_q[$];
  int valid_cycles = 0;
  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string name, input int act, input int want);
    test_cnt++;
    if (act != want) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Monitor
  logic             prev_stall = 1'b0;
  logic             prev_done  = 1'b0;
  logic [WIDTH-1:0] prev_dir   = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
      prev_done  <= 1'b0;
    end else begin
      if (!out_valid) check("idle_dir_zero", int'(out_dir), 0);
      else valid_cycles <= valid_cycles + 1;
      if (prev_stall) begin
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_dir_held", int'(out_dir), int'(prev_dir));
      end
      if (out_valid && out_ready) begin
        hs_cyc_q.push_back(cyc);
        check("sb_has_entry", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("out_dir", int'(out_dir), int'(exp_q.pop_front()));
      end
      if (stack_pop) begin
        pop_cyc_q.push_back(cyc);
        check("pop_while_nonempty", int'(stack_empty), 0);
      end
      if (done) begin
        done_cyc_q.push_back(cyc);
        check("done_single_cycle", int'(prev_done), 0);
      end
      prev_stall <= out_valid && !out_ready;
      prev_dir   <= out_dir;
      prev_done  <= done;
    end
  end

  // Driver tasks (inputs change 1 time unit after the rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input bit expect_out);
    push_en   = 1'b1;
    push_data = d;
    tick();
    push_en = 1'b0;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic do_start(output int c);
    start = 1'b1;
    c     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget, input string name);
    int i = 0;
    while (done_cyc_q.size() == n0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, int'(done_cyc_q.size() > n0), 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int i = 0;
    while (!out_valid && i < budget) begin
      tick();
      i++;
    end
    check(name, int'(out_valid), 1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int i = 0;
    while (state != s && i < budget) begin
      tick();
      i++;
    end
    check(name, int'(state), int'(s));
  endtask

  task automatic check_run(input string tag, input int c, input int np, input int nh,
                           input int nd, input int n_pop, input int n_hs,
                           input int exp_len, input int exp_ovf, input bit b2b);
    int pops;
    int hss;
    pops = pop_cyc_q.size() - np;
    hss  = hs_cyc_q.size() - nh;
    check({tag, "_pops"}, pops, n_pop);
    if (pops > 0) begin
      check({tag, "_pop_latency"}, pop_cyc_q[np] - c, 2);
      for (int k = 1; k < pops; k++)
        check({tag, "_pop_spacing"}, pop_cyc_q[np+k] - pop_cyc_q[np+k-1], 2);
    end
    check({tag, "_xfers"}, hss, n_hs);
    if (b2b && hss > 1)
      check({tag, "_back_to_back"}, hs_cyc_q[nh+hss-1] - hs_cyc_q[nh], hss - 1);
    check({tag, "_done_count"}, done_cyc_q.size() - nd, 1);
    check({tag, "_path_len"}, int'(path_len), exp_len);
    check({tag, "_overflow"}, int'(overflow), exp_ovf);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    tick();
    check({tag, "_busy_low"}, int'(busy), 0);
    check({tag, "_state_idle"}, int'(state), 0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  bit rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [WIDTH-1:0] path4 [4] = '{2'b01, 2'b00, 2'b00, 2'b11};

  initial begin
    int c, np, nh, nd, nv;

    // Reset values
    repeat (3) tick();
    check("rst_stack_pop", int'(stack_pop), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_dir", int'(out_dir), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_path_len", int'(path_len), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_state", int'(state), 0);
    reset = 1'b0;
    tick();

    // Asynchronous reset while PLAY holds out_valid
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(path4[i], 1'b1);
    do_start(c);
    wait_valid(100, "t1_reach_play");
    check("t1_pre_path_len", int'(path_len), 4);
    #1 reset = 1'b1;
    #1;
    check("t1_async_valid", int'(out_valid), 0);
    check("t1_async_busy", int'(busy), 0);
    check("t1_async_pop", int'(stack_pop), 0);
    check("t1_async_path_len", int'(path_len), 0);
    check("t1_async_state", int'(state), 0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();

    // 4-move path, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(path4[i], 1'b1);
    np = pop_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    do_start(c);
    wait_done(nd, 100, "t2_done_seen");
    check_run("t2", c, np, nh, nd, 4, 4, 4, 0, 1'b1);
    check_idle("t2");

    // Same path with out_ready stalls
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(path4[i], 1'b1);
    np = pop_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    do_start(c);
    wait_valid(100, "t3_reach_play");
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy_pat[i];
      tick();
    end
    out_ready = 1'b1;
    wait_done(nd, 100, "t3_done_seen");
    check_run("t3", c, np, nh, nd, 4, 4, 4, 0, 1'b0);
    check_idle("t3");

    // Empty stack
    np = pop_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size(); nv = valid_cycles;
    do_start(c);
    wait_done(nd, 20, "t4_done_seen");
    check_run("t4", c, np, nh, nd, 0, 0, 0, 0, 1'b0);
    if (done_cyc_q.size() > nd) check("t4_done_latency", done_cyc_q[nd] - c, 2);
    check("t4_no_valid", valid_cycles - nv, 0);
    check_idle("t4");

    // Full 256-entry path; start pulses in CAPTURE and PLAY are ignored
    for (int i = 0; i < DEPTH; i++) push(WIDTH'(i % 4), 1'b1);
    np = pop_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    do_start(c);
    wait_state(3'd3, 20, "t5_reach_capture");
    start = 1'b1; tick(); start = 1'b0;
    wait_state(3'd4, 1000, "t5_reach_play");
    start = 1'b1; tick(); start = 1'b0;
    wait_done(nd, 2000, "t5_done_seen");
    check_run("t5", c, np, nh, nd, DEPTH, DEPTH, DEPTH, 0, 1'b1);
    check_idle("t5");
    repeat (3) tick();
    check("t6_no_restart_busy", int'(busy), 0);
    check("t6_no_extra_done", done_cyc_q.size() - nd, 1);
    check("t6_no_extra_pops", pop_cyc_q.size() - np, DEPTH);

    // 257 entries: drain stops at DEPTH and flags overflow
    push(2'd0, 1'b0);
    for (int i = 1; i <= DEPTH; i++) push(WIDTH'(i % 4), 1'b1);
    np = pop_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    do_start(c);
    wait_done(nd, 2000, "t7_done_seen");
    check_run("t7", c, np, nh, nd, DEPTH, DEPTH, DEPTH, 1, 1'b1);
    check("t7_stack_left", stk_cnt, 1);
    repeat (3) tick();
    check("t7_ovf_sticky", int'(overflow), 1);
    check("t7_len_held", int'(path_len), DEPTH);

    // Next start clears overflow and drains the remaining entry
    exp_q.push_back(2'd0);
    np = pop_cyc_q.size(); nh = hs_cyc_q.size(); nd = done_cyc_q.size();
    do_start(c);
    wait_done(nd, 100, "t8_done_seen");
    check_run("t8", c, np, nh, nd, 1, 1, 1, 0, 1'b1);
    check("t8_stack_empty", stk_cnt, 0);
    check_idle("t8");

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
